dcpu_mem_resp: RTL and testbench

DCPU_MEM_RESP -- requirements
Module: dcpu_mem_resp

---
 rtl/dcpu_mem_resp.sv | 119 +++++++++++
 tb/tb_dcpu_mem_resp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_mem_resp.sv
// Dual-port word memory for a DCPU-style core: optional clear and boot-stream load
// after reset, then a CPU read/write port plus a read-only device port.
module dcpu_mem_resp #(
    parameter int ADDR_W         = 16,
    parameter int BOOT_LEN       = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic        CORE_CLK,
    input  logic        RESET,
    input  logic [15:0] RAM_addr,
    input  logic [15:0] RAM_out,
    input  logic        RAM_wr,
    output logic [15:0] RAM_data,
    output logic        CPU_stall,
    input  logic        BOOT_valid,
    input  logic [15:0] BOOT_word,
    output logic        BOOT_ready,
    output logic        BOOT_done,
    input  logic        DEV_req,
    input  logic [15:0] DEV_addr,
    output logic        DEV_ack,
    output logic [15:0] DEV_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_LEN - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_BOOT, ST_RUN} state_t;

    localparam state_t BOOT_OR_RUN = (BOOT_LEN > 0) ? ST_BOOT : ST_RUN;
    localparam state_t INIT_STATE  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : BOOT_OR_RUN;

    logic [15:0]       mem [DEPTH];
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  clear_cnt_reg, boot_cnt_reg;
    logic [15:0]       ram_data_reg, dev_data_reg;
    logic              dev_ack_reg, cpu_stall_reg, boot_ready_reg, boot_done_reg;
    logic              wr_en, boot_accept;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] cpu_addr, dev_addr;

    assign cpu_addr = RAM_addr[ADDR_W-1:0];
    assign dev_addr = DEV_addr[ADDR_W-1:0];

    // Single write port shared by clear, boot load and CPU writes.
    always_comb begin
        state_next  = state_reg;
        wr_en       = 1'b0;
        wr_addr     = cpu_addr;
        wr_data     = RAM_out;
        boot_accept = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clear_cnt_reg[ADDR_W-1:0];
                wr_data = '0;
                if (clear_cnt_reg == CLEAR_LAST) state_next = BOOT_OR_RUN;
            end
            ST_BOOT: begin
                if (BOOT_valid) begin
                    boot_accept = 1'b1;
                    wr_en       = 1'b1;
                    wr_addr     = boot_cnt_reg[ADDR_W-1:0];
                    wr_data     = BOOT_word;
                    if (boot_cnt_reg == BOOT_LAST) state_next = ST_RUN;
                end
            end
            ST_RUN:  wr_en = RAM_wr;
            default: state_next = INIT_STATE;
        endcase
        if (RESET) wr_en = 1'b0;
    end

    always_ff @(posedge CORE_CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CORE_CLK) begin
        if (RESET) begin
            state_reg      <= INIT_STATE;
            clear_cnt_reg  <= '0;
            boot_cnt_reg   <= '0;
            ram_data_reg   <= '0;
            dev_data_reg   <= '0;
            dev_ack_reg    <= 1'b0;
            boot_done_reg  <= 1'b0;
            cpu_stall_reg  <= (INIT_STATE != ST_RUN);
            boot_ready_reg <= (INIT_STATE == ST_BOOT);
        end else begin
            state_reg      <= state_next;
            cpu_stall_reg  <= (state_next != ST_RUN);
            boot_done_reg  <= (state_next == ST_RUN);
            boot_ready_reg <= (state_next == ST_BOOT);
            if (state_reg == ST_CLEAR) clear_cnt_reg <= clear_cnt_reg + CNT_W'(1);
            if (boot_accept) boot_cnt_reg <= boot_cnt_reg + CNT_W'(1);

            if (state_reg == ST_RUN) ram_data_reg <= RAM_wr ? RAM_out : mem[cpu_addr];
            else ram_data_reg <= '0;

            // Skipping the cycle after an ack spaces out grants for a held request;
            // the array read here sees the pre-write word on a same-address collision.
            if (state_reg == ST_RUN && DEV_req && !dev_ack_reg) begin
                dev_data_reg <= mem[dev_addr];
                dev_ack_reg  <= 1'b1;
            end else begin
                dev_ack_reg  <= 1'b0;
            end
        end
    end

    assign RAM_data   = ram_data_reg;
    assign DEV_data   = dev_data_reg;
    assign DEV_ack    = dev_ack_reg;
    assign CPU_stall  = cpu_stall_reg;
    assign BOOT_ready = boot_ready_reg;
    assign BOOT_done  = boot_done_reg;
endmodule

// File: tb/tb_dcpu_mem_resp.sv
// Bench for dcpu_mem_resp: a boot-loading instance (ADDR_W=16, BOOT_LEN=4) and a
// clearing instance (ADDR_W=4, CLEAR_ON_RESET=1), each checked against a word-level model.
module tb_dcpu_mem_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic        a_rst, a_wr, a_bvalid, a_dreq;
    logic [15:0] a_addr, a_wdata, a_bword, a_daddr;
    logic [15:0] a_ram_data, a_dev_data;
    logic        a_stall, a_bready, a_bdone, a_dack;

    logic        c_rst, c_wr, c_bvalid, c_dreq;
    logic [15:0] c_addr, c_wdata, c_bword, c_daddr;
    logic [15:0] c_ram_data, c_dev_data;
    logic        c_stall, c_bready, c_bdone, c_dack;

    dcpu_mem_resp #(.ADDR_W(16), .BOOT_LEN(4), .CLEAR_ON_RESET(0)) dut_a (
        .CORE_CLK(clk), .RESET(a_rst), .RAM_addr(a_addr), .RAM_out(a_wdata), .RAM_wr(a_wr),
        .RAM_data(a_ram_data), .CPU_stall(a_stall), .BOOT_valid(a_bvalid), .BOOT_word(a_bword),
        .BOOT_ready(a_bready), .BOOT_done(a_bdone), .DEV_req(a_dreq), .DEV_addr(a_daddr),
        .DEV_ack(a_dack), .DEV_data(a_dev_data)
    );

    dcpu_mem_resp #(.ADDR_W(4), .BOOT_LEN(0), .CLEAR_ON_RESET(1)) dut_c (
        .CORE_CLK(clk), .RESET(c_rst), .RAM_addr(c_addr), .RAM_out(c_wdata), .RAM_wr(c_wr),
        .RAM_data(c_ram_data), .CPU_stall(c_stall), .BOOT_valid(c_bvalid), .BOOT_word(c_bword),
        .BOOT_ready(c_bready), .BOOT_done(c_bdone), .DEV_req(c_dreq), .DEV_addr(c_daddr),
        .DEV_ack(c_dack), .DEV_data(c_dev_data)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model of instance A: word memory, boot progress and whether a grant was just given.
    logic [15:0] a_mem_m [int];
    bit          a_run_m;
    int          a_cnt_m;
    bit          a_ack_m;

    function automatic logic [15:0] a_rd(input logic [15:0] ad);
        if (a_mem_m.exists(int'(ad))) return a_mem_m[int'(ad)];
        return 16'hxxxx;
    endfunction

    task automatic step_a();
        logic [15:0] exp_ram, exp_dev;
        bit          exp_ack;
        exp_ram = '0;
        exp_dev = '0;
        exp_ack = 1'b0;
        if (a_rst) begin
            a_run_m = 1'b0;
            a_cnt_m = 0;
            a_ack_m = 1'b0;
        end else if (!a_run_m) begin
            if (a_bvalid) begin
                a_mem_m[a_cnt_m] = a_bword;
                a_cnt_m++;
                if (a_cnt_m == 4) a_run_m = 1'b1;
            end
            a_ack_m = 1'b0;
        end else begin
            exp_ram = a_wr ? a_wdata : a_rd(a_addr);
            if (a_dreq && !a_ack_m) begin
                exp_ack = 1'b1;
                exp_dev = a_rd(a_daddr);
            end
            a_ack_m = exp_ack;
            if (a_wr) a_mem_m[int'(a_addr)] = a_wdata;
        end
        @(posedge clk);
        #1;
        $display("[A] t=%0t rst=%0b wr=%0b addr=%04h ram=%04h stall=%0b done=%0b ack=%0b dev=%04h",
                 $time, a_rst, a_wr, a_addr, a_ram_data, a_stall, a_bdone, a_dack, a_dev_data);
        check_value("a_ram_data", 32'(a_ram_data), 32'(exp_ram));
        check_value("a_dev_ack", 32'(a_dack), 32'(exp_ack));
        if (exp_ack) check_value("a_dev_data", 32'(a_dev_data), 32'(exp_dev));
        check_value("a_cpu_stall", 32'(a_stall), 32'(!a_run_m));
        check_value("a_boot_done", 32'(a_bdone), 32'(a_run_m));
        check_value("a_boot_ready", 32'(a_bready), 32'(!a_run_m));
    endtask

    // Model of instance C: 16 words, addresses alias modulo 16, clear takes 16 cycles.
    logic [15:0] c_mem_m [16];
    int          c_clr_m;
    bit          c_ack_m;

    task automatic step_c();
        logic [15:0] exp_ram, exp_dev;
        bit          exp_ack;
        exp_ram = '0;
        exp_dev = '0;
        exp_ack = 1'b0;
        if (c_rst) begin
            c_clr_m = 16;
            c_ack_m = 1'b0;
        end else if (c_clr_m > 0) begin
            c_mem_m[16 - c_clr_m] = '0;
            c_clr_m--;
            c_ack_m = 1'b0;
        end else begin
            exp_ram = c_wr ? c_wdata : c_mem_m[int'(c_addr[3:0])];
            if (c_dreq && !c_ack_m) begin
                exp_ack = 1'b1;
                exp_dev = c_mem_m[int'(c_daddr[3:0])];
            end
            c_ack_m = exp_ack;
            if (c_wr) c_mem_m[int'(c_addr[3:0])] = c_wdata;
        end
        @(posedge clk);
        #1;
        $display("[C] t=%0t rst=%0b wr=%0b addr=%04h ram=%04h stall=%0b done=%0b ack=%0b dev=%04h",
                 $time, c_rst, c_wr, c_addr, c_ram_data, c_stall, c_bdone, c_dack, c_dev_data);
        check_value("c_ram_data", 32'(c_ram_data), 32'(exp_ram));
        check_value("c_dev_ack", 32'(c_dack), 32'(exp_ack));
        if (exp_ack) check_value("c_dev_data", 32'(c_dev_data), 32'(exp_dev));
        check_value("c_cpu_stall", 32'(c_stall), 32'(c_clr_m > 0));
        check_value("c_boot_done", 32'(c_bdone), 32'(c_clr_m == 0 && !c_rst));
        check_value("c_boot_ready", 32'(c_bready), 32'(0));
    endtask

    task automatic count_clear_stall(input string tag);
        int n;
        n = 0;
        while (c_stall === 1'b1 && n < 40) begin
            n++;
            step_c();
        end
        check_value(tag, 32'(n), 32'(16));
    endtask

    logic [15:0] stream [4];
    logic [15:0] pool [8];

    initial begin
        stream[0] = 16'h7C01; stream[1] = 16'h0030; stream[2] = 16'h7DE1; stream[3] = 16'h1000;
        a_rst = 1'b1; a_wr = 1'b0; a_bvalid = 1'b0; a_dreq = 1'b0;
        a_addr = '0; a_wdata = '0; a_bword = '0; a_daddr = '0;
        c_rst = 1'b1; c_wr = 1'b0; c_bvalid = 1'b0; c_dreq = 1'b0;
        c_addr = '0; c_wdata = '0; c_bword = '0; c_daddr = '0;

        step_a(); step_a();
        a_rst = 1'b0;

        // Reset mid-boot, then a full re-stream.
        a_bvalid = 1'b1; a_bword = 16'hDEAD; step_a();
        a_bword = 16'hBEEF; step_a();
        a_bvalid = 1'b0; a_rst = 1'b1; step_a();
        a_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_bvalid = 1'b1;
            a_bword = 16'(16'h1111 * (i + 1));
            step_a();
        end
        a_bvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_addr = 16'(i);
            step_a();
            check_value("reboot_word", 32'(a_ram_data), 32'(16'h1111 * (i + 1)));
        end
        a_wr = 1'b1; a_addr = 16'h0004; a_wdata = 16'h4E4E; step_a();
        a_wr = 1'b0;

        // Gapped boot with a CPU write and a device request raised during BOOT.
        a_rst = 1'b1; step_a();
        a_rst = 1'b0;
        a_dreq = 1'b1; a_daddr = 16'h0001; a_addr = 16'h0002; a_wdata = 16'h9999;
        for (int i = 0; i < 10; i++) begin
            a_bvalid = (i % 2 == 0) || (i == 8);
            a_bword = (i < 8) ? stream[i / 2] : 16'hFFFF;
            a_wr = (i == 5);
            step_a();
        end
        a_dreq = 1'b0; a_bvalid = 1'b0; a_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_addr = 16'(i);
            step_a();
        end
        check_value("boot_len_exact", 32'(a_ram_data), 32'(16'h4E4E));
        a_addr = 16'h0002; step_a();
        check_value("stall_write_ignored", 32'(a_ram_data), 32'(16'h7DE1));

        // CPU write-through and read-back.
        a_wr = 1'b1; a_addr = 16'h1234; a_wdata = 16'hBEEF; step_a();
        check_value("write_through", 32'(a_ram_data), 32'(16'hBEEF));
        a_wr = 1'b0; step_a();
        check_value("read_after_write", 32'(a_ram_data), 32'(16'hBEEF));
        a_addr = 16'h0000; step_a();
        check_value("read_boot_word0", 32'(a_ram_data), 32'(16'h7C01));

        // Device collision: old word returned, then new word on a later request.
        a_wr = 1'b1; a_addr = 16'h0100; a_wdata = 16'hAAAA; step_a();
        a_wdata = 16'h5555; a_dreq = 1'b1; a_daddr = 16'h0100; step_a();
        check_value("collision_ack", 32'(a_dack), 32'(1));
        check_value("collision_old", 32'(a_dev_data), 32'(16'hAAAA));
        a_wr = 1'b0; a_dreq = 1'b0; step_a();
        check_value("ack_single_pulse", 32'(a_dack), 32'(0));
        a_dreq = 1'b1; step_a();
        check_value("collision_new", 32'(a_dev_data), 32'(16'h5555));
        a_dreq = 1'b0; step_a();

        // Randomized traffic over a small address pool.
        for (int k = 0; k < 8; k++) begin
            pool[k] = 16'($urandom);
            a_wr = 1'b1; a_addr = pool[k]; a_wdata = 16'($urandom);
            step_a();
        end
        for (int k = 0; k < 300; k++) begin
            a_wr = 1'($urandom_range(0, 1));
            a_addr = pool[$urandom_range(0, 7)];
            a_wdata = 16'($urandom);
            a_dreq = 1'($urandom_range(0, 1));
            a_daddr = pool[$urandom_range(0, 7)];
            a_bvalid = 1'($urandom_range(0, 1));
            a_bword = 16'($urandom);
            step_a();
        end
        a_wr = 1'b0; a_dreq = 1'b0; a_bvalid = 1'b0;

        // Clearing instance: stall length, preload, aborted clear, full clear.
        step_c();
        c_rst = 1'b0;
        count_clear_stall("clear_stall_cycles");
        for (int i = 0; i < 16; i++) begin
            c_wr = 1'b1;
            c_addr = 16'(i + 16 * $urandom_range(0, 4095));
            c_wdata = 16'($urandom_range(1, 65535));
            step_c();
        end
        c_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c_addr = 16'(i);
            step_c();
        end
        c_rst = 1'b1; step_c();
        c_rst = 1'b0;
        for (int i = 0; i < 5; i++) step_c();
        c_rst = 1'b1; step_c();
        c_rst = 1'b0;
        count_clear_stall("clear_stall_cycles_restart");
        for (int i = 0; i < 16; i++) begin
            c_addr = 16'(i + 16 * $urandom_range(0, 4095));
            step_c();
            check_value("cleared_word", 32'(c_ram_data), 32'(0));
        end
        for (int k = 0; k < 150; k++) begin
            c_wr = 1'($urandom_range(0, 1));
            c_addr = 16'($urandom);
            c_wdata = 16'($urandom);
            c_dreq = 1'($urandom_range(0, 1));
            c_daddr = 16'($urandom);
            step_c();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
